// File: rtl/rf_pkg.sv
// Shared register-file constants: architectural register count, index width,
// default pending-write counter width and the register index type.
package rf_pkg;

  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;
  localparam int CNT_W_DEF = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue handshake, writeback and flush bundle between the decode stage
// (master) and the register scoreboard (slave).
interface reg_scoreboard_if;
  import rf_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_rs1;
  reg_idx_t issue_rs2;
  reg_idx_t issue_rd;
  logic     issue_rs1_used;
  logic     issue_rs2_used;
  logic     issue_rd_wr;
  logic     issue_ready;
  logic     wb_valid;
  reg_idx_t wb_rd;
  logic     flush;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_rs1_used, issue_rs2_used, issue_rd_wr,
           wb_valid, wb_rd, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_rs1_used, issue_rs2_used, issue_rd_wr,
           wb_valid, wb_rd, flush,
    output issue_ready
  );

endinterface

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register. Increment and
// decrement in the same cycle cancel; clear wins over both. Saturates at
// the top, and a lone decrement at zero holds zero and flags underflow.
module sb_counter
  import rf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count and underflow detection
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             underflow_o = 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register
// and stalls issue on read-after-write hazards or a full pending counter.
// Register 0 is hardwired untracked. Hazards see registered counts only,
// so a writeback unblocks readers from the following cycle.
// Optional build macro REG_SCOREBOARD_STATS_EN adds stall_cnt_o, a wrapping
// count of cycles where an instruction was presented but not accepted.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG  = rf_pkg::NREG,
  parameter int CNT_W = rf_pkg::CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  reg_scoreboard_if.slave     sb_if,
  output logic [NREG-1:0]     busy_vec_o,
  output logic                err_o
`ifdef REG_SCOREBOARD_STATS_EN
  , output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            underflow;
  logic                       issue_fire;
  logic                       err_q;

  assign cnt[0]       = '0;
  assign underflow[0] = 1'b0;

  // issue ready from registered state; flush always blocks issue
  always_comb begin
    sb_if.issue_ready = !sb_if.flush;
    if (sb_if.issue_rs1_used && busy_vec_o[sb_if.issue_rs1]) sb_if.issue_ready = 1'b0;
    if (sb_if.issue_rs2_used && busy_vec_o[sb_if.issue_rs2]) sb_if.issue_ready = 1'b0;
    if (sb_if.issue_rd_wr && (cnt[sb_if.issue_rd] == CNT_MAX)) sb_if.issue_ready = 1'b0;
  end

  assign issue_fire = sb_if.issue_valid && sb_if.issue_ready && sb_if.issue_rd_wr;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_i       (issue_fire && (sb_if.issue_rd == reg_idx_t'(i))),
      .dec_i       (sb_if.wb_valid && (sb_if.wb_rd == reg_idx_t'(i))),
      .clr_i       (sb_if.flush),
      .cnt_o       (cnt[i]),
      .underflow_o (underflow[i])
    );
  end

  // busy decode of the registered counters
  always_comb begin
    busy_vec_o = '0;
    for (int i = 0; i < NREG; i++) busy_vec_o[i] = |cnt[i];
  end

  // sticky writeback-underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (|underflow);
  end

  assign err_o = err_q;

`ifdef REG_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;

  // count presented-but-stalled cycles, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          stall_cnt_q <= '0;
    else if (sb_if.issue_valid && !sb_if.issue_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: NREG, default 32, number of architectural registers; index width 5.
REQ-002 Parameter: CNT_W, default 2, per-register pending-write counter width; CNT_MAX = 2^CNT_W-1.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 issue_valid  in  1  decode stage presents an instruction.
REQ-006 issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register indices.
REQ-007 issue_rs1_used, issue_rs2_used, issue_rd_wr  in  1 each  operand-read and destination-write qualifiers.
REQ-008 issue_ready  out  1  high when the presented instruction may issue this cycle.
REQ-009 wb_valid  in  1, wb_rd  in  5  writeback completion to the register file write port.
REQ-010 flush  in  1  pipeline flush; discards all in-flight writes.
REQ-011 busy_vec  out  NREG  bit i high when counter i is nonzero.
REQ-012 err  out  1  sticky writeback-underflow flag.

Function
REQ-013 Issue handshake: an instruction issues when issue_valid and issue_ready are both high in the same cycle.
REQ-014 issue_ready is low when any of the following holds: rs1_used and busy(rs1); rs2_used and busy(rs2); rd_wr and count(rd)==CNT_MAX; or flush is high. Otherwise it is high, independent of issue_valid.
REQ-015 Hazard evaluation uses registered counters only, with no writeback bypass: a wb in cycle N unblocks readers from cycle N+1.
REQ-016 An issue with rd_wr=1 and rd!=0 increments count(rd) at the next edge.
REQ-017 wb_valid with wb_rd!=0 decrements count(wb_rd) at the next edge.
REQ-018 Issue and wb to the same rd in the same cycle leave count(rd) unchanged.
REQ-019 Register 0 is never tracked: count(0) stays 0, busy_vec[0] stays 0, and rs=0 never stalls.
REQ-020 A wb to a register whose count is 0 (and no same-cycle issue to it) leaves the count at 0 and sets err; err holds until reset.
REQ-021 A flush clears all counters at the next edge; wb_valid and issue in that cycle are ignored for counting.
REQ-022 busy_vec is a registered-state decode, with zero combinational path from the inputs.
REQ-023 Latency: ready depends combinationally on the inputs and state; counter and busy update one cycle after the event.

Reset
REQ-024 On rst: all counters are 0, busy_vec=0, err=0, and issue_ready follows REQ-014 (high when flush is low).
REQ-025 Reset asserted mid-operation discards all pending writes immediately; there is no replay.

Configuration
REQ-026 With macro REG_SCOREBOARD_STATS_EN defined, adds output stall_cnt (32 bits). It counts cycles with issue_valid=1 and issue_ready=0, wraps at 2^32, and resets to 0.
REQ-027 Without REG_SCOREBOARD_STATS_EN: the stall_cnt port and its counter are absent, and all other behaviour is identical.

Structure
REQ-028 Shared package rf_pkg holds: the NREG and register-index width constants, the CNT_W default, and the reg_idx_t typedef; regfile uses the same package.
REQ-029 One sub-module, sb_counter: a single per-register up/down/clear saturating counter, instantiated NREG-1 times (indices 1..NREG-1).

Verification
REQ-030 Issue rd=5 (rd_wr=1) at cycle 1. Then rs1=5 at cycle 2: expect ready=0 and busy_vec[5]=1. wb_rd=5 at cycle 3: expect ready=1 at cycle 4.
REQ-031 Issue rd=0 and rs1=0 repeatedly: expect ready=1 always, busy_vec=0, err=0.
REQ-032 Issue rd=7 three times (CNT_W=2): count=3, and a fourth issue to rd=7 sees ready=0. One wb to 7: the next cycle sees ready=1.
REQ-033 Issue rd=9 and wb rd=9 in the same cycle with count(9)=1: expect count(9)=1 after the edge and busy_vec[9]=1.
REQ-034 Load rd=3, 4, 6, then assert flush: the next cycle has busy_vec=0, and ready=0 during the flush cycle.
REQ-035 wb_rd=12 with count 0: err=1 and remains 1 until rst. With REG_SCOREBOARD_STATS_EN, 4 stalled cycles give stall_cnt=4.
